recirculacion_param: RTL

- Parametrised, registered recirculation stage for the PCIe lane datapath.
- Each lane's valid word is steered to one of two paths:
  - the mux path, toward the downstream mux/FIFO;
  - the recirculation path, back to the source/checker.
- Steering is driven by a flow-control FSM that watches downstream backpressure, with resume hysteresis.
- Generalises the fixed 4-lane, 8-bit combinational splitter to N lanes, arbitrary width, 1-cycle registered outputs and a recirculated-word counter.

---
 rtl/recirculacion_param.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/recirculacion_param.sv
// Registered N-lane splitter steering valid words to the mux path or the
// recirculation path under a backpressure FSM; RECIRC_STATS_EN enables recirc_count.
module recirculacion_param #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RESUME_DLY = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_LANES-1:0]        valid_in,
  input  logic [NUM_LANES*DATA_W-1:0] data_in,
  input  logic                        pause_in,
  output logic [NUM_LANES-1:0]        valid_mux_out,
  output logic [NUM_LANES*DATA_W-1:0] data_mux_out,
  output logic [NUM_LANES-1:0]        valid_recirc_out,
  output logic [NUM_LANES*DATA_W-1:0] data_recirc_out,
  output logic                        paused_out,
  output logic [CNT_W-1:0]            recirc_count
);

  localparam int unsigned RW = (RESUME_DLY < 2) ? 1 : $clog2(RESUME_DLY + 1);

  typedef enum logic [1:0] {
    FWD    = 2'd0,
    HOLD   = 2'd1,
    RESUME = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [RW-1:0]                 rcnt_q, rcnt_d;
  logic [NUM_LANES-1:0]          vmux_q, vmux_d;
  logic [NUM_LANES-1:0]          vrec_q, vrec_d;
  logic [NUM_LANES*DATA_W-1:0]   dmux_q, dmux_d;
  logic [NUM_LANES*DATA_W-1:0]   drec_q, drec_d;

  // rcnt holds the number of low pause samples seen so far; FWD is entered on
  // the edge that delivers the RESUME_DLY-th consecutive low sample.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      FWD: begin
        if (pause_in) state_d = HOLD;
      end
      HOLD: begin
        if (!pause_in) begin
          if (RESUME_DLY <= 1) begin
            state_d = FWD;
            rcnt_d  = '0;
          end else begin
            state_d = RESUME;
            rcnt_d  = RW'(1);
          end
        end
      end
      RESUME: begin
        if (pause_in) begin
          state_d = HOLD;
          rcnt_d  = '0;
        end else if (rcnt_q == RW'(RESUME_DLY - 1)) begin
          state_d = FWD;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      default: begin
        state_d = FWD;
        rcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    vmux_d = '0;
    vrec_d = '0;
    dmux_d = '0;
    drec_d = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (valid_in[i]) begin
        if (state_q == FWD) begin
          vmux_d[i]                 = 1'b1;
          dmux_d[i*DATA_W +: DATA_W] = data_in[i*DATA_W +: DATA_W];
        end else begin
          vrec_d[i]                 = 1'b1;
          drec_d[i*DATA_W +: DATA_W] = data_in[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FWD;
      rcnt_q  <= '0;
      vmux_q  <= '0;
      vrec_q  <= '0;
      dmux_q  <= '0;
      drec_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      vmux_q  <= vmux_d;
      vrec_q  <= vrec_d;
      dmux_q  <= dmux_d;
      drec_q  <= drec_d;
    end
  end

`ifdef RECIRC_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   pop;
  logic [CNT_W:0]   sum;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      pop = pop + (CNT_W+1)'(vrec_d[i]);
    end
    sum = {1'b0, cnt_q} + pop;
    if (sum[CNT_W]) cnt_d = '1;
    else            cnt_d = sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign recirc_count = cnt_q;
`else
  assign recirc_count = '0;
`endif

  assign valid_mux_out    = vmux_q;
  assign data_mux_out     = dmux_q;
  assign valid_recirc_out = vrec_q;
  assign data_recirc_out  = drec_q;
  assign paused_out       = (state_q != FWD);

endmodule
